// File: rtl/run_feeder.sv
// rtl/run_feeder.sv - feeds bundles from a source FIFO into alternating runs on two destination FIFOs
// Optional key-order checking is compiled in with RUN_FEEDER_ORDER_CHECK_EN.
module run_feeder #(
    parameter int DATA_WIDTH   = 32,
    parameter int KEY_WIDTH    = 32,
    parameter int BUNDLE_WIDTH = 8,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_start,
    input  logic [5:0]                         i_run_log2,
    input  logic [CNT_WIDTH-1:0]               i_total_len,
    input  logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] i_src_data,
    input  logic                               i_src_vld,
    output logic                               o_src_read,
    input  logic                               i_fifo_0_full,
    input  logic                               i_fifo_1_full,
    output logic [DATA_WIDTH*BUNDLE_WIDTH:0]   o_fifo_data_0,
    output logic [DATA_WIDTH*BUNDLE_WIDTH:0]   o_fifo_data_1,
    output logic                               o_fifo_0_write,
    output logic                               o_fifo_1_write,
    output logic                               o_busy,
    output logic                               o_done,
    output logic                               o_cfg_err,
    output logic                               o_order_err
);
    typedef enum logic [1:0] {IDLE, FEED_0, FEED_1, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_WIDTH-1:0] total_cnt_q, total_cnt_d;
    logic [CNT_WIDTH-1:0] run_last_q, run_last_d;
    logic [CNT_WIDTH-1:0] total_len_q, total_len_d;
    logic                 cfg_err_q, cfg_err_d;
    logic [CNT_WIDTH-1:0] two_run_mask;
    logic                 start_ok;
    logic                 dest_full;
    logic                 xfer;
    logic                 last;

`ifdef RUN_FEEDER_ORDER_CHECK_EN
    localparam int KEY_LSB = DATA_WIDTH - KEY_WIDTH;
    logic                 order_err_q, order_err_d;
    logic [KEY_WIDTH-1:0] prev_max_q, prev_max_d;
    logic [KEY_WIDTH-1:0] bundle_max;
    logic                 bundle_sorted;

    always_comb begin
        bundle_sorted = 1'b1;
        bundle_max    = i_src_data[KEY_LSB +: KEY_WIDTH];
        for (int i = 1; i < BUNDLE_WIDTH; i++) begin
            if (i_src_data[i*DATA_WIDTH+KEY_LSB +: KEY_WIDTH] <
                i_src_data[(i-1)*DATA_WIDTH+KEY_LSB +: KEY_WIDTH])
                bundle_sorted = 1'b0;
            if (i_src_data[i*DATA_WIDTH+KEY_LSB +: KEY_WIDTH] > bundle_max)
                bundle_max = i_src_data[i*DATA_WIDTH+KEY_LSB +: KEY_WIDTH];
        end
    end
    assign o_order_err = order_err_q;
`else
    assign o_order_err = 1'b0;
`endif

    // A pass must cover a whole number of run pairs so it ends on FIFO 1.
    assign two_run_mask = (CNT_WIDTH'(1) << ({1'b0, i_run_log2} + 7'd1)) - CNT_WIDTH'(1);
    assign start_ok     = (i_total_len != '0) && (int'(i_run_log2) < CNT_WIDTH - 1) &&
                          ((i_total_len & two_run_mask) == '0);

    assign dest_full = (state_q == FEED_1) ? i_fifo_1_full : i_fifo_0_full;
    assign xfer      = i_rst_n && (state_q == FEED_0 || state_q == FEED_1) &&
                       i_src_vld && !dest_full;
    assign last      = (run_cnt_q == run_last_q);

    assign o_src_read     = xfer;
    assign o_fifo_0_write = xfer && (state_q == FEED_0);
    assign o_fifo_1_write = xfer && (state_q == FEED_1);
    assign o_fifo_data_0  = {last, i_src_data};
    assign o_fifo_data_1  = {last, i_src_data};
    assign o_busy         = i_rst_n && (state_q != IDLE);
    assign o_done         = i_rst_n && (state_q == DONE);
    assign o_cfg_err      = cfg_err_q;

    always_comb begin
        state_d     = state_q;
        run_cnt_d   = run_cnt_q;
        total_cnt_d = total_cnt_q;
        run_last_d  = run_last_q;
        total_len_d = total_len_q;
        cfg_err_d   = cfg_err_q;
`ifdef RUN_FEEDER_ORDER_CHECK_EN
        order_err_d = order_err_q;
        prev_max_d  = prev_max_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (start_ok) begin
                        run_last_d  = (CNT_WIDTH'(1) << i_run_log2) - CNT_WIDTH'(1);
                        total_len_d = i_total_len;
                        run_cnt_d   = '0;
                        total_cnt_d = '0;
                        cfg_err_d   = 1'b0;
`ifdef RUN_FEEDER_ORDER_CHECK_EN
                        order_err_d = 1'b0;
`endif
                        state_d     = FEED_0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            FEED_0, FEED_1: begin
                if (xfer) begin
                    total_cnt_d = total_cnt_q + CNT_WIDTH'(1);
`ifdef RUN_FEEDER_ORDER_CHECK_EN
                    prev_max_d = bundle_max;
                    if (!bundle_sorted ||
                        (run_cnt_q != '0 && i_src_data[KEY_LSB +: KEY_WIDTH] < prev_max_q))
                        order_err_d = 1'b1;
`endif
                    if (last) begin
                        run_cnt_d = '0;
                        if (total_cnt_d == total_len_q)
                            state_d = DONE;
                        else
                            state_d = (state_q == FEED_0) ? FEED_1 : FEED_0;
                    end else begin
                        run_cnt_d = run_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            run_cnt_q   <= '0;
            total_cnt_q <= '0;
            run_last_q  <= '0;
            total_len_q <= '0;
            cfg_err_q   <= 1'b0;
`ifdef RUN_FEEDER_ORDER_CHECK_EN
            order_err_q <= 1'b0;
            prev_max_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            total_cnt_q <= total_cnt_d;
            run_last_q  <= run_last_d;
            total_len_q <= total_len_d;
            cfg_err_q   <= cfg_err_d;
`ifdef RUN_FEEDER_ORDER_CHECK_EN
            order_err_q <= order_err_d;
            prev_max_q  <= prev_max_d;
`endif
        end
    end
endmodule

// File: tb/tb_run_feeder.sv
// tb/tb_run_feeder.sv - self-checking bench for run_feeder against a transfer-count reference model
module tb_run_feeder;
    localparam int DW = 32, KW = 32, NB = 8, CW = 32, BW = DW * NB;

    logic          i_clk = 1'b0;
    logic          i_rst_n, i_start, i_src_vld, i_fifo_0_full, i_fifo_1_full;
    logic [5:0]    i_run_log2;
    logic [CW-1:0] i_total_len;
    logic [BW-1:0] i_src_data;
    logic          o_src_read, o_fifo_0_write, o_fifo_1_write;
    logic          o_busy, o_done, o_cfg_err, o_order_err;
    logic [BW:0]   o_fifo_data_0, o_fifo_data_1;

    run_feeder #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .BUNDLE_WIDTH(NB), .CNT_WIDTH(CW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_run_log2(i_run_log2),
        .i_total_len(i_total_len), .i_src_data(i_src_data), .i_src_vld(i_src_vld),
        .o_src_read(o_src_read), .i_fifo_0_full(i_fifo_0_full), .i_fifo_1_full(i_fifo_1_full),
        .o_fifo_data_0(o_fifo_data_0), .o_fifo_data_1(o_fifo_data_1),
        .o_fifo_0_write(o_fifo_0_write), .o_fifo_1_write(o_fifo_1_write),
        .o_busy(o_busy), .o_done(o_done), .o_cfg_err(o_cfg_err), .o_order_err(o_order_err));

    always #5 i_clk = ~i_clk;

    int checks = 0, errors = 0;

    // Reference model: phase 0 idle, 1 feeding, 2 done pulse; m_n counts bundles moved.
    int            m_phase = 0, m_n = 0, m_total = 0, m_log2 = 0;
    bit            m_cfg_err = 0, m_order_err = 0;
    logic [KW-1:0] m_prev_max = '0;
    bit            rnd_mode = 0;

    int wr_dest[$];
    bit wr_last[$];
    int busy_cycles;

    typedef struct {
        int            l2;
        logic [CW-1:0] tot;
        bit            acc;
    } cfg_vec_t;
    cfg_vec_t tbl[11];

    task automatic chk(input string name, input logic [BW:0] act, input logic [BW:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit start_ok(input int l2, input logic [CW-1:0] tot);
        if (tot == 0 || l2 >= CW - 1) return 0;
        return (64'(tot) % (64'd2 << l2)) == 0;
    endfunction

    task automatic tick();
        int            dest, runlen;
        bit            xfer, exp_last, sorted;
        logic [KW-1:0] k, kmax, kprev;
        @(negedge i_clk);
        if (rnd_mode) begin
            i_src_vld     = ($urandom_range(3) != 0);
            i_fifo_0_full = ($urandom_range(3) == 0);
            i_fifo_1_full = ($urandom_range(3) == 0);
            i_start       = ($urandom_range(15) == 0) && (m_phase != 0);
            for (int r = 0; r < NB; r++) i_src_data[r*DW +: DW] = $urandom;
            #1;
        end
        runlen   = 1 << m_log2;
        dest     = (m_n / runlen) % 2;
        xfer     = i_rst_n && m_phase == 1 && i_src_vld &&
                   !(dest == 1 ? i_fifo_1_full : i_fifo_0_full);
        exp_last = ((m_n + 1) % runlen) == 0;
        chk("src_read", o_src_read, xfer);
        chk("fifo_0_write", o_fifo_0_write, xfer && dest == 0);
        chk("fifo_1_write", o_fifo_1_write, xfer && dest == 1);
        chk("busy", o_busy, i_rst_n && m_phase != 0);
        chk("done", o_done, i_rst_n && m_phase == 2);
        chk("cfg_err", o_cfg_err, m_cfg_err);
        chk("order_err", o_order_err, m_order_err);
        if (xfer) chk("fifo_data", dest == 1 ? o_fifo_data_1 : o_fifo_data_0, {exp_last, i_src_data});
        if (o_fifo_0_write || o_fifo_1_write) begin
            wr_dest.push_back(o_fifo_1_write ? 1 : 0);
            wr_last.push_back(o_fifo_1_write ? o_fifo_data_1[BW] : o_fifo_data_0[BW]);
        end
        if (o_busy) busy_cycles++;
        @(posedge i_clk);
        if (!i_rst_n) begin
            m_phase = 0; m_cfg_err = 0; m_order_err = 0;
        end else if (m_phase == 0) begin
            if (i_start) begin
                if (start_ok(int'(i_run_log2), i_total_len)) begin
                    m_phase = 1; m_n = 0; m_total = int'(i_total_len); m_log2 = int'(i_run_log2);
                    m_cfg_err = 0; m_order_err = 0;
                end else m_cfg_err = 1;
            end
        end else if (m_phase == 1) begin
            if (xfer) begin
`ifdef RUN_FEEDER_ORDER_CHECK_EN
                sorted = 1; kmax = '0; kprev = '0;
                for (int r = 0; r < NB; r++) begin
                    k = i_src_data[r*DW + DW - KW +: KW];
                    if (r > 0 && k < kprev) sorted = 0;
                    if (r == 0 || k > kmax) kmax = k;
                    kprev = k;
                end
                if (!sorted || (m_n % runlen != 0 &&
                    i_src_data[DW-KW +: KW] < m_prev_max)) m_order_err = 1;
                m_prev_max = kmax;
`endif
                m_n++;
                if (m_n == m_total) m_phase = 2;
            end
        end else m_phase = 0;
        #1;
    endtask

    task automatic start_pass(input int l2, input logic [CW-1:0] tot);
        i_run_log2  = 6'(l2);
        i_total_len = tot;
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
    endtask

    task automatic run_to_idle(input int budget);
        int n = 0;
        while (m_phase != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (m_phase != 0) begin
            errors++;
            $display("FAIL pass_timeout: still busy after %0d cycles, required idle", n);
            m_phase = 0;
        end
        rnd_mode = 0;
        i_start  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_dest[8];
        bit exp_lst[8];
        exp_dest = '{0, 0, 1, 1, 0, 0, 1, 1};
        exp_lst  = '{0, 1, 0, 1, 0, 1, 0, 1};
        tbl[0]  = '{1, 8, 1};   tbl[1]  = '{0, 4, 1};    tbl[2]  = '{1, 6, 0};
        tbl[3]  = '{0, 0, 0};   tbl[4]  = '{2, 8, 1};    tbl[5]  = '{2, 12, 0};
        tbl[6]  = '{0, 2, 1};   tbl[7]  = '{31, 4, 0};   tbl[8]  = '{40, 256, 0};
        tbl[9]  = '{3, 16, 1};  tbl[10] = '{0, 3, 0};

        i_rst_n = 1'b0; i_start = 1'b0; i_src_vld = 1'b1; i_fifo_0_full = 1'b0;
        i_fifo_1_full = 1'b0; i_run_log2 = 6'd1; i_total_len = 8; i_src_data = '0;
        #1;
        i_start = 1'b1;
        tick();
        tick();
        i_start = 1'b0;
        i_rst_n = 1'b1;
        tick();

        // Two-bundle runs over eight bundles.
        wr_dest.delete(); wr_last.delete();
        for (int r = 0; r < NB; r++) i_src_data[r*DW +: DW] = r;
        start_pass(1, 8);
        run_to_idle(40);
        chk("seq_a_count", 257'(wr_dest.size()), 257'd8);
        for (int i = 0; i < 8 && i < wr_dest.size(); i++) begin
            chk("seq_a_dest", 257'(wr_dest[i]), 257'(exp_dest[i]));
            chk("seq_a_last", 257'(wr_last[i]), 257'(exp_lst[i]));
        end

        // Single-bundle runs: busy spans four transfers plus the done cycle.
        wr_dest.delete(); wr_last.delete();
        start_pass(0, 4);
        busy_cycles = 0;
        run_to_idle(40);
        chk("seq_b_busy_cycles", 257'(busy_cycles), 257'd5);
        for (int i = 0; i < wr_dest.size(); i++) begin
            chk("seq_b_dest", 257'(wr_dest[i]), 257'(i % 2));
            chk("seq_b_last", 257'(wr_last[i]), 257'd1);
        end

        // Rejected start followed by an accepted one.
        wr_dest.delete();
        start_pass(1, 6);
        tick();
        chk("seq_c_cfg_err", o_cfg_err, 1'b1);
        chk("seq_c_no_writes", 257'(wr_dest.size()), 257'd0);
        start_pass(1, 4);
        chk("seq_c_cfg_clear", o_cfg_err, 1'b0);
        run_to_idle(40);

        // FIFO 0 backpressure while FIFO 1 fullness toggles.
        wr_dest.delete();
        start_pass(1, 8);
        tick();
        i_fifo_0_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_fifo_1_full = (i % 2 == 0);
            tick();
        end
        i_fifo_0_full = 1'b0; i_fifo_1_full = 1'b0;
        run_to_idle(40);
        chk("seq_d_count", 257'(wr_dest.size()), 257'd8);

        // Reset after three bundles, then restart.
        wr_dest.delete(); wr_last.delete();
        start_pass(1, 8);
        repeat (3) tick();
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();
        chk("seq_e_writes_before_reset", 257'(wr_dest.size()), 257'd3);
        start_pass(1, 8);
        tick();
        chk("seq_e_restart_dest", 257'(wr_dest[wr_dest.size()-1]), 257'd0);
        chk("seq_e_restart_last", 257'(wr_last[wr_last.size()-1]), 257'd0);
        run_to_idle(40);

`ifdef RUN_FEEDER_ORDER_CHECK_EN
        for (int r = 0; r < NB; r++) i_src_data[r*DW +: DW] = 2 + r;
        start_pass(1, 4);
        tick();
        for (int r = 0; r < NB; r++) i_src_data[r*DW +: DW] = (r == 0) ? 5 : 9;
        tick();
        i_src_vld = 1'b0;
        tick();
        chk("seq_f_order_err", o_order_err, 1'b1);
        i_src_vld = 1'b1;
        for (int r = 0; r < NB; r++) i_src_data[r*DW +: DW] = 100;
        run_to_idle(40);
        chk("seq_f_order_err_held", o_order_err, 1'b1);
        start_pass(0, 2);
        chk("seq_f_order_err_clear", o_order_err, 1'b0);
        run_to_idle(40);
`endif

        for (int v = 0; v < 11; v++) begin
            start_pass(tbl[v].l2, tbl[v].tot);
            chk("tbl_cfg_err", o_cfg_err, !tbl[v].acc);
            chk("tbl_busy", o_busy, tbl[v].acc);
            run_to_idle(200);
        end

        for (int p = 0; p < 20; p++) begin
            int l2;
            l2 = $urandom_range(3);
            start_pass(l2, CW'($urandom_range(1, 3) * (2 << l2)));
            rnd_mode = 1;
            run_to_idle(1000);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
